// File: rtl/chacha20_block_ctrl_if.sv
// rtl/chacha20_block_ctrl_if.sv - request, datapath-control and keystream handshake bundle
interface chacha20_block_ctrl_if #(
  parameter int BLK_CNT_W = 16
);
  logic                 start;
  logic [BLK_CNT_W-1:0] num_blocks;
  logic [31:0]          ctr_init;
  logic                 abort;
  logic                 state_load;
  logic [31:0]          ctr_out;
  logic                 round_en;
  logic                 round_sel;
  logic                 add_en;
  logic                 ks_valid;
  logic                 ks_ready;
  logic                 busy;
  logic                 done;
  logic                 ctr_overflow;

  // Front end / keystream consumer side
  modport master (
    output start, num_blocks, ctr_init, abort, ks_ready,
    input  state_load, ctr_out, round_en, round_sel, add_en,
    input  ks_valid, busy, done, ctr_overflow
  );

  // Block controller side
  modport slave (
    input  start, num_blocks, ctr_init, abort, ks_ready,
    output state_load, ctr_out, round_en, round_sel, add_en,
    output ks_valid, busy, done, ctr_overflow
  );
endinterface

// File: rtl/chacha20_block_ctrl.sv
// rtl/chacha20_block_ctrl.sv - per-block sequencer for the ChaCha20 keystream datapath
module chacha20_block_ctrl #(
  parameter int NUM_DOUBLE_ROUNDS = 10,
  parameter int BLK_CNT_W         = 16
) (
  input logic                    clk,
  input logic                    reset,
  chacha20_block_ctrl_if.slave   bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  // Up to 30 half-rounds fit in 5 bits
  localparam logic [4:0] LAST_ROUND = 5'(2 * NUM_DOUBLE_ROUNDS - 1);

  logic [2:0]           state_q,        state_d;
  logic [4:0]           round_idx_q,    round_idx_d;
  logic [4:0]           round_idx_inc;
  logic [BLK_CNT_W-1:0] blocks_left_q,  blocks_left_d;
  logic [31:0]          ctr_q,          ctr_d;
  logic                 ovf_q,          ovf_d;
  logic                 state_load_q,   state_load_d;
  logic                 round_en_q,     round_en_d;
  logic                 round_sel_q,    round_sel_d;
  logic                 add_en_q,       add_en_d;
  logic                 ks_valid_q,     ks_valid_d;
  logic                 busy_q,         busy_d;
  logic                 done_q,         done_d;

  assign round_idx_inc = round_idx_q + 5'd1;

  // Next-state and registered-output decode; outputs describe the state being entered
  always_comb begin
    state_d       = state_q;
    round_idx_d   = round_idx_q;
    blocks_left_d = blocks_left_q;
    ctr_d         = ctr_q;
    ovf_d         = ovf_q;
    state_load_d  = 1'b0;
    round_en_d    = 1'b0;
    round_sel_d   = 1'b0;
    add_en_d      = 1'b0;
    ks_valid_d    = 1'b0;
    done_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.num_blocks != '0) begin
            ctr_d         = bus.ctr_init;
            blocks_left_d = bus.num_blocks;
            ovf_d         = 1'b0;
            state_d       = S_LOAD;
            state_load_d  = 1'b1;
          end else begin
            // Empty request completes immediately without touching the datapath
            done_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        state_d     = S_ROUND;
        round_idx_d = 5'd0;
        round_en_d  = 1'b1;
        round_sel_d = 1'b0;
      end

      S_ROUND: begin
        if (round_idx_q == LAST_ROUND) begin
          state_d     = S_ADD;
          round_idx_d = 5'd0;
          add_en_d    = 1'b1;
        end else begin
          round_idx_d = round_idx_inc;
          round_en_d  = 1'b1;
          round_sel_d = round_idx_inc[0];
        end
      end

      S_ADD: begin
        state_d    = S_OUT;
        ks_valid_d = 1'b1;
      end

      S_OUT: begin
        if (bus.ks_ready) begin
          if (blocks_left_q == BLK_CNT_W'(1)) begin
            done_d        = 1'b1;
            blocks_left_d = '0;
            state_d       = S_IDLE;
          end else if (ctr_q == 32'hFFFF_FFFF) begin
            // Never emit a block with a wrapped counter; end the request with an error
            ovf_d         = 1'b1;
            done_d        = 1'b1;
            blocks_left_d = '0;
            state_d       = S_IDLE;
          end else begin
            blocks_left_d = blocks_left_q - BLK_CNT_W'(1);
            ctr_d         = ctr_q + 32'd1;
            state_d       = S_LOAD;
            state_load_d  = 1'b1;
          end
        end else begin
          ks_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything; overflow flag and counter are left as they are
    if (bus.abort) begin
      state_d       = S_IDLE;
      round_idx_d   = 5'd0;
      blocks_left_d = '0;
      state_load_d  = 1'b0;
      round_en_d    = 1'b0;
      round_sel_d   = 1'b0;
      add_en_d      = 1'b0;
      ks_valid_d    = 1'b0;
      done_d        = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      round_idx_q   <= 5'd0;
      blocks_left_q <= '0;
      ctr_q         <= 32'd0;
      ovf_q         <= 1'b0;
      state_load_q  <= 1'b0;
      round_en_q    <= 1'b0;
      round_sel_q   <= 1'b0;
      add_en_q      <= 1'b0;
      ks_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      round_idx_q   <= round_idx_d;
      blocks_left_q <= blocks_left_d;
      ctr_q         <= ctr_d;
      ovf_q         <= ovf_d;
      state_load_q  <= state_load_d;
      round_en_q    <= round_en_d;
      round_sel_q   <= round_sel_d;
      add_en_q      <= add_en_d;
      ks_valid_q    <= ks_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.state_load   = state_load_q;
  assign bus.ctr_out      = ctr_q;
  assign bus.round_en     = round_en_q;
  assign bus.round_sel    = round_sel_q;
  assign bus.add_en       = add_en_q;
  assign bus.ks_valid     = ks_valid_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.ctr_overflow = ovf_q;

endmodule

// File: tb/tb_chacha20_block_ctrl.sv
// tb/tb_chacha20_block_ctrl.sv - self-checking bench for chacha20_block_ctrl
module tb_chacha20_block_ctrl;

  localparam int NDR = 10;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   model_ovf;
  bit   model_ovf_known;

  always #5 clk = ~clk;

  chacha20_block_ctrl_if #(.BLK_CNT_W(16)) bus ();

  chacha20_block_ctrl #(.NUM_DOUBLE_ROUNDS(NDR), .BLK_CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    bit          sl;
    logic [31:0] ctr;
    bit          chk_ctr;
    bit          re;
    bit          rs;
    bit          ae;
    bit          kv;
    bit          by;
    bit          dn;
    bit          ov;
    bit          chk_ov;
    bit          rdy;
  } cyc_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk_bit({tag, "_state_load"}, bus.state_load, 1'b0);
    chk_bit({tag, "_round_en"},   bus.round_en,   1'b0);
    chk_bit({tag, "_add_en"},     bus.add_en,     1'b0);
    chk_bit({tag, "_ks_valid"},   bus.ks_valid,   1'b0);
    chk_bit({tag, "_busy"},       bus.busy,       1'b0);
    chk_bit({tag, "_done"},       bus.done,       1'b0);
  endtask

  task automatic check_cycle(input cyc_t e);
    chk_bit("state_load", bus.state_load, e.sl);
    chk_bit("round_en",   bus.round_en,   e.re);
    chk_bit("round_sel",  bus.round_sel,  e.rs);
    chk_bit("add_en",     bus.add_en,     e.ae);
    chk_bit("ks_valid",   bus.ks_valid,   e.kv);
    chk_bit("busy",       bus.busy,       e.by);
    chk_bit("done",       bus.done,       e.dn);
    if (e.chk_ctr) chk_word("ctr_out", bus.ctr_out, e.ctr);
    if (e.chk_ov)  chk_bit("ctr_overflow", bus.ctr_overflow, e.ov);
  endtask

  // Reference model: expand a request into its expected cycle-by-cycle timeline, then
  // drive it (random ready outside OUT, random ignored starts while busy) and compare.
  task automatic run_request(input logic [31:0] ci, input int n,
                             input int stall_lo, input int stall_hi);
    cyc_t        q[$];
    cyc_t        e;
    longint      rem;
    int          nb;
    int          st;
    bit          ov;
    logic [31:0] c;
    rem = 64'h1_0000_0000 - longint'(ci);
    nb  = (longint'(n) > rem) ? int'(rem) : n;
    ov  = (n > nb);
    c   = ci;
    for (int b = 0; b < nb; b++) begin
      c = ci + 32'(b);
      e = '{sl:1, ctr:c, chk_ctr:1, re:0, rs:0, ae:0, kv:0, by:1, dn:0, ov:0, chk_ov:1, rdy:1'($urandom)};
      q.push_back(e);
      for (int r = 0; r < 2 * NDR; r++) begin
        e = '{sl:0, ctr:c, chk_ctr:1, re:1, rs:1'(r % 2), ae:0, kv:0, by:1, dn:0, ov:0, chk_ov:1, rdy:1'($urandom)};
        q.push_back(e);
      end
      e = '{sl:0, ctr:c, chk_ctr:1, re:0, rs:0, ae:1, kv:0, by:1, dn:0, ov:0, chk_ov:1, rdy:1'($urandom)};
      q.push_back(e);
      st = $urandom_range(stall_hi, stall_lo);
      for (int s = 0; s <= st; s++) begin
        e = '{sl:0, ctr:c, chk_ctr:1, re:0, rs:0, ae:0, kv:1, by:1, dn:0, ov:0, chk_ov:1, rdy:(s == st)};
        q.push_back(e);
      end
    end
    e = '{sl:0, ctr:c, chk_ctr:(n > 0), re:0, rs:0, ae:0, kv:0, by:0, dn:1, ov:ov, chk_ov:(n > 0), rdy:1'($urandom)};
    q.push_back(e);

    bus.start      = 1'b1;
    bus.num_blocks = 16'(n);
    bus.ctr_init   = ci;
    bus.ks_ready   = 1'($urandom);
    step();
    foreach (q[i]) begin
      check_cycle(q[i]);
      bus.ks_ready   = q[i].rdy;
      bus.start      = q[i].by ? 1'($urandom_range(1, 0)) : 1'b0;
      bus.num_blocks = 16'($urandom);
      bus.ctr_init   = $urandom;
      step();
    end
    bus.start = 1'b0;
    check_idle("post_done");
    if (n > 0) begin
      chk_bit("post_done_ctr_overflow", bus.ctr_overflow, ov);
      model_ovf       = ov;
      model_ovf_known = 1'b1;
    end else begin
      model_ovf_known = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] rci;
    bus.start      = 1'b0;
    bus.num_blocks = '0;
    bus.ctr_init   = '0;
    bus.abort      = 1'b0;
    bus.ks_ready   = 1'b0;
    reset          = 1'b1;
    model_ovf       = 1'b0;
    model_ovf_known = 1'b0;
    repeat (3) step();

    check_idle("reset");
    chk_word("reset_ctr_out", bus.ctr_out, 32'd0);
    chk_bit("reset_ctr_overflow", bus.ctr_overflow, 1'b0);
    chk_bit("reset_round_sel", bus.round_sel, 1'b0);
    reset = 1'b0;
    step();

    // Single block, no stall
    run_request(32'd1, 1, 0, 0);
    // Three blocks, four-cycle stall each
    run_request(32'd5, 3, 4, 4);
    // Counter wrap stops after FFFFFFFF with overflow flagged
    run_request(32'hFFFF_FFFE, 3, 0, 3);
    // Next accepted start clears the overflow flag
    run_request(32'd0, 1, 0, 2);
    // Exact fit up to the top of the counter space: no overflow
    run_request(32'hFFFF_FFFD, 3, 0, 1);
    // Empty request
    run_request(32'h1234_5678, 0, 0, 0);

    for (int k = 0; k < 6; k++) begin
      rci = ($urandom_range(1, 0) == 1) ? (32'hFFFF_FFFF - 32'($urandom_range(3, 0))) : $urandom;
      run_request(rci, $urandom_range(4, 1), 0, 5);
    end
    run_request(32'd9, 2, 0, 1);

    // Abort during half-round 7: idle next cycle, no add_en, no done, flag unchanged
    bus.ks_ready   = 1'b1;
    bus.start      = 1'b1;
    bus.num_blocks = 16'd2;
    bus.ctr_init   = 32'd100;
    step();
    bus.start = 1'b0;
    repeat (8) step();
    chk_bit("abort_pre_round_en", bus.round_en, 1'b1);
    chk_bit("abort_pre_round_sel", bus.round_sel, 1'b1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check_idle("abort");
    if (model_ovf_known) chk_bit("abort_ctr_overflow", bus.ctr_overflow, model_ovf);
    for (int k = 0; k < 25; k++) begin
      chk_bit("abort_no_add_en", bus.add_en, 1'b0);
      chk_bit("abort_no_done", bus.done, 1'b0);
      step();
    end

    // Reset while a block waits in OUT
    bus.ks_ready   = 1'b0;
    bus.start      = 1'b1;
    bus.num_blocks = 16'd1;
    bus.ctr_init   = 32'd7;
    step();
    bus.start = 1'b0;
    repeat (2 * NDR + 2) step();
    chk_bit("pre_reset_ks_valid", bus.ks_valid, 1'b1);
    chk_word("pre_reset_ctr_out", bus.ctr_out, 32'd7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("mid_reset");
    chk_word("mid_reset_ctr_out", bus.ctr_out, 32'd0);
    chk_bit("mid_reset_ctr_overflow", bus.ctr_overflow, 1'b0);
    run_request(32'd1, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
